// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcodes,
// PC source and ALU select codes, and the decoded instruction class.
package mips_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_BRANCH = 3'd5,
        ST_JUMP   = 3'd6
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] PC_NPC = 2'b00;
    localparam logic [1:0] PC_BTA = 2'b01;
    localparam logic [1:0] PC_JTA = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic rtype;
        logic addi;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/datapath bundle: datapath status into the control unit, register
// load enables and PC/RF/memory/ALU controls out of it.
interface mc_ctrl_fsm_if #(parameter int OP_WIDTH = 6);
    logic [OP_WIDTH-1:0] i_opcode;
    logic [OP_WIDTH-1:0] i_funct;
    logic                i_zero;
    logic                i_mem_ready;
    logic                o_en_inst_n;
    logic                o_en_npc_n;
    logic                o_en_a_n;
    logic                o_en_b_n;
    logic                o_en_bta_n;
    logic                o_en_r_n;
    logic                o_en_d_n;
    logic                o_mem_rd;
    logic                o_mem_wr;
    logic                o_iord;
    logic                o_pc_we;
    logic [1:0]          o_pc_src;
    logic                o_rf_we;
    logic                o_rf_dst;
    logic                o_rf_src;
    logic [1:0]          o_alu_sel;
    logic                o_alu_srcb_imm;

    modport master (
        input  i_opcode, i_funct, i_zero, i_mem_ready,
        output o_en_inst_n, o_en_npc_n, o_en_a_n, o_en_b_n, o_en_bta_n, o_en_r_n, o_en_d_n,
        output o_mem_rd, o_mem_wr, o_iord, o_pc_we, o_pc_src,
        output o_rf_we, o_rf_dst, o_rf_src, o_alu_sel, o_alu_srcb_imm
    );

    modport slave (
        output i_opcode, i_funct, i_zero, i_mem_ready,
        input  o_en_inst_n, o_en_npc_n, o_en_a_n, o_en_b_n, o_en_bta_n, o_en_r_n, o_en_d_n,
        input  o_mem_rd, o_mem_wr, o_iord, o_pc_we, o_pc_src,
        input  o_rf_we, o_rf_dst, o_rf_src, o_alu_sel, o_alu_srcb_imm
    );
endinterface

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: exactly one bit of the class is set,
// anything outside the supported set reports illegal.
module mc_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OP_WIDTH = 6
) (
    input  logic [OP_WIDTH-1:0] i_opcode,
    output op_class_t           o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_RTYPE: o_class.rtype   = 1'b1;
            OP_ADDI:  o_class.addi    = 1'b1;
            OP_LW:    o_class.lw      = 1'b1;
            OP_SW:    o_class.sw      = 1'b1;
            OP_BEQ:   o_class.beq     = 1'b1;
            OP_J:     o_class.j       = 1'b1;
            default:  o_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences INST/A/B/R/D/BTA/NPC loads and PC,
// RF, memory and ALU controls; stalls on i_mem_ready and counts retirements.
module mc_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int OP_WIDTH  = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    mc_ctrl_fsm_if.master        dp,
    output logic                 o_illegal,
    output logic [CNT_WIDTH-1:0] o_retired,
    output logic [2:0]           o_state
);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [CNT_WIDTH-1:0] r_retired;
    op_class_t            w_cls;

    mc_op_decode #(.OP_WIDTH(OP_WIDTH)) u_dec (
        .i_opcode (dp.i_opcode),
        .o_class  (w_cls)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next = dp.i_mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                if (w_cls.beq)      w_next = ST_BRANCH;
                else if (w_cls.j)   w_next = ST_JUMP;
                else if (!w_cls.illegal) w_next = ST_EXEC;
                else                w_next = ST_FETCH;
            end
            ST_EXEC:   w_next = (w_cls.lw || w_cls.sw) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (!dp.i_mem_ready) w_next = ST_MEM;
                else if (w_cls.lw)   w_next = ST_WB;
                else                 w_next = ST_FETCH;
            end
            default:   w_next = ST_FETCH;
        endcase
    end

    // Outputs are held inactive for the whole reset cycle so an aborted
    // instruction never writes the PC or register file.
    always_comb begin
        dp.o_en_inst_n    = 1'b1;
        dp.o_en_npc_n     = 1'b1;
        dp.o_en_a_n       = 1'b1;
        dp.o_en_b_n       = 1'b1;
        dp.o_en_bta_n     = 1'b1;
        dp.o_en_r_n       = 1'b1;
        dp.o_en_d_n       = 1'b1;
        dp.o_mem_rd       = 1'b0;
        dp.o_mem_wr       = 1'b0;
        dp.o_iord         = 1'b0;
        dp.o_pc_we        = 1'b0;
        dp.o_pc_src       = PC_NPC;
        dp.o_rf_we        = 1'b0;
        dp.o_rf_dst       = 1'b0;
        dp.o_rf_src       = 1'b0;
        dp.o_alu_sel      = ALU_ADD;
        dp.o_alu_srcb_imm = 1'b0;
        o_illegal         = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_FETCH: begin
                    dp.o_mem_rd = 1'b1;
                    if (dp.i_mem_ready) begin
                        dp.o_en_inst_n = 1'b0;
                        dp.o_en_npc_n  = 1'b0;
                    end
                end
                ST_DECODE: begin
                    dp.o_en_a_n   = 1'b0;
                    dp.o_en_b_n   = 1'b0;
                    dp.o_en_bta_n = 1'b0;
                    if (w_cls.illegal) begin
                        o_illegal  = 1'b1;
                        dp.o_pc_we = 1'b1;
                    end
                end
                ST_EXEC: begin
                    dp.o_en_r_n = 1'b0;
                    if (w_cls.rtype) dp.o_alu_sel = ALU_FUNCT;
                    else             dp.o_alu_srcb_imm = 1'b1;
                end
                ST_MEM: begin
                    dp.o_iord = 1'b1;
                    if (w_cls.lw) begin
                        dp.o_mem_rd = 1'b1;
                        dp.o_en_d_n = !dp.i_mem_ready;
                    end else begin
                        dp.o_mem_wr = 1'b1;
                        dp.o_pc_we  = dp.i_mem_ready;
                    end
                end
                ST_WB: begin
                    dp.o_rf_we  = 1'b1;
                    dp.o_rf_dst = w_cls.rtype;
                    dp.o_rf_src = w_cls.lw;
                    dp.o_pc_we  = 1'b1;
                end
                ST_BRANCH: begin
                    dp.o_alu_sel = ALU_SUB;
                    dp.o_pc_we   = 1'b1;
                    dp.o_pc_src  = dp.i_zero ? PC_BTA : PC_NPC;
                end
                ST_JUMP: begin
                    dp.o_pc_we  = 1'b1;
                    dp.o_pc_src = PC_JTA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)           r_retired <= '0;
        else if (dp.o_pc_we) r_retired <= r_retired + CNT_WIDTH'(1);
    end

    assign o_retired = i_rst ? '0 : r_retired;
    assign o_state   = i_rst ? 3'd0 : r_state;

endmodule
